// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks a register file through its debug read port and
// streams every word to a UART transmitter, MS byte first, behind a 0xA5
// header byte. Uses a valid/ready byte handshake and stalls freely on the UART.
module reg_dump_streamer #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [4:0]       dbg_sel,
    input  logic [WIDTH-1:0] dbg_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [4:0]    LAST_REG  = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_byte;
    logic [4:0]        r_idx;
    logic [WIDTH-1:0]  r_shift;
    logic              w_last_byte;

    assign w_last_byte = (r_byte == LAST_BYTE);

    // State register; reset drops straight back to IDLE so an aborted dump never resumes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and all outputs decode from the current state only.
    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;
        dbg_sel  = r_idx;
        case (r_state)
            S_IDLE: begin
                dbg_sel = 5'd0;
                if (start) w_next = S_HEADER;
            end
            S_HEADER: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) w_next = S_LOAD;
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = r_shift[WIDTH-1 -: 8];
                if (tx_ready && w_last_byte)
                    w_next = (r_idx == LAST_REG) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: snapshot the word in LOAD, then shift one byte out per acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_byte <= '0;
                        r_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift <= dbg_data;
                    r_byte  <= '0;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_shift <= r_shift << 8;
                        if (w_last_byte) begin
                            r_byte <= '0;
                            if (r_idx != LAST_REG) r_idx <= r_idx + 5'd1;
                        end else begin
                            r_byte <= r_byte + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: default 32x32 instance plus a
// 1-register, 16-bit instance for the smallest configuration.
module tb_reg_dump_streamer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        tx_ready = 1'b1;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    logic        start2 = 1'b0;
    logic [4:0]  dbg_sel2;
    logic [15:0] dbg_data2;
    logic [7:0]  tx_data2;
    logic        tx_valid2, busy2, done2;

    logic [31:0] regs [32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign dbg_data  = regs[dbg_sel];
    assign dbg_data2 = 16'h0000;

    reg_dump_streamer dut (
        .clk(clk), .reset(reset), .start(start), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    reg_dump_streamer #(.WIDTH(16), .NUM_REGS(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .dbg_sel(dbg_sel2),
        .dbg_data(dbg_data2), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(1'b1), .busy(busy2), .done(done2)
    );

    // Monitor: sampled on the falling edge, inputs only change just after the rising edge.
    logic [7:0] q[$];
    logic [7:0] q2[$];
    logic [7:0] exp_q[$];
    int   busy_cyc, done_cyc, busy2_cyc, stall_bad;
    logic stall_pend;
    logic [7:0] stall_byte;
    logic clr = 1'b0;

    always @(negedge clk) begin
        if (clr) begin
            q.delete(); q2.delete();
            busy_cyc = 0; done_cyc = 0; busy2_cyc = 0; stall_bad = 0;
            stall_pend = 1'b0;
        end else begin
            if (busy)  busy_cyc++;
            if (done)  done_cyc++;
            if (busy2) busy2_cyc++;
            if (stall_pend && !reset && (tx_valid !== 1'b1 || tx_data !== stall_byte)) stall_bad++;
            if (tx_valid && tx_ready) q.push_back(tx_data);
            if (tx_valid2) q2.push_back(tx_data2);
            stall_pend = tx_valid && !tx_ready && !reset;
            stall_byte = tx_data;
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high about 30% of cycles
    task automatic run_dump(input int mode, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            if (done_cyc > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [31:0] r5);
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 32; k++) begin
            w = (k == 0) ? 32'h0 : (k == 5) ? r5 : 32'h1000_0000 + k;
            exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        total++; if (dbg_sel !== 5'd0) begin bad++; $display("FAIL rst_dbg_sel got=%0d exp=0", dbg_sel); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_full_dump();
        bit ok;
        int mis;
        tx_ready = 1'b1;
        build_exp(32'h1000_0005);
        clear_mon();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start_after_reset busy got=%b exp=1", busy); end
        run_dump(0, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_timeout got=no_done exp=done"); end
        total++; if (q.size() != 129) begin bad++; $display("FAIL full_len got=%0d exp=129", q.size()); end
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= q.size() || q[i] !== exp_q[i])) mis = i;
        total++; if (mis >= 0) begin bad++; $display("FAIL full_stream byte %0d got=%h exp=%h", mis, (mis < q.size()) ? q[mis] : 8'hxx, exp_q[mis]); end
        total++; if (busy_cyc != 161) begin bad++; $display("FAIL full_busy_cycles got=%0d exp=161", busy_cyc); end
        total++; if (done_cyc != 1) begin bad++; $display("FAIL full_done_cycles got=%0d exp=1", done_cyc); end
        total++; if (dbg_sel !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_dump dbg_sel=%0d busy=%b exp=0,0", dbg_sel, busy); end
    endtask

    task automatic test_stall_random();
        bit ok;
        int mis;
        build_exp(32'h1000_0005);
        clear_mon();
        pulse_start();
        run_dump(1, 5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=no_done exp=done"); end
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= q.size() || q[i] !== exp_q[i])) mis = i;
        total++; if (mis >= 0 || q.size() != 129) begin bad++; $display("FAIL stall_stream len=%0d idx=%0d exp_len=129", q.size(), mis); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stall_bad); end
    endtask

    task automatic test_snapshot();
        bit stalled = 1'b0;
        bit ok = 1'b0;
        int mis;
        regs[5] = 32'hDEAD_BEEF;
        build_exp(32'hDEAD_BEEF);
        tx_ready = 1'b1;
        clear_mon();
        pulse_start();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (!stalled && q.size() >= 22) begin
                tx_ready = 1'b0;
                stalled = 1'b1;
                repeat (3) @(posedge clk);
                #1 regs[5] = 32'h0;
                repeat (3) @(posedge clk);
                #1;
                total++; if (tx_valid !== 1'b1 || tx_data !== 8'hAD) begin bad++; $display("FAIL snap_stalled_byte got=%b/%h exp=1/ad", tx_valid, tx_data); end
                tx_ready = 1'b1;
            end
            if (done_cyc > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (!ok) begin bad++; $display("FAIL snap_timeout got=no_done exp=done"); end
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= q.size() || q[i] !== exp_q[i])) mis = i;
        total++; if (mis >= 0 || q.size() != 129) begin bad++; $display("FAIL snap_stream len=%0d idx=%0d exp_len=129", q.size(), mis); end
        regs[5] = 32'h1000_0005;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        tx_ready = 1'b1;
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        repeat (80) @(posedge clk);
        pulse_start();
        run_dump(0, 1000, ok);
        repeat (10) @(posedge clk);
        #1;
        total++; if (q.size() != 129) begin bad++; $display("FAIL b2b_len got=%0d exp=129", q.size()); end
        total++; if (done_cyc != 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done_cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        bit hit = 1'b0;
        bit ok;
        int n, mis;
        clear_mon();
        tx_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (tx_valid && dbg_sel == 5'd12) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL abort_reach_reg12 got=no exp=yes"); end
        #2 reset = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || dbg_sel !== 5'd0) begin
            bad++; $display("FAIL abort_immediate valid=%b busy=%b sel=%0d exp=0,0,0", tx_valid, busy, dbg_sel);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = q.size();
        repeat (20) @(posedge clk);
        #1;
        total++; if (q.size() != n || busy !== 1'b0) begin bad++; $display("FAIL abort_no_resume got=%0d bytes busy=%b exp=%0d,0", q.size(), busy, n); end
        build_exp(32'h1000_0005);
        clear_mon();
        pulse_start();
        run_dump(0, 1000, ok);
        total++; if (q.size() == 0 || q[0] !== 8'hA5) begin bad++; $display("FAIL abort_restart_header got=%h exp=a5", (q.size() > 0) ? q[0] : 8'hxx); end
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= q.size() || q[i] !== exp_q[i])) mis = i;
        total++; if (!ok || mis >= 0 || q.size() != 129) begin bad++; $display("FAIL abort_restart_stream len=%0d idx=%0d exp_len=129", q.size(), mis); end
    endtask

    task automatic test_small();
        clear_mon();
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (q2.size() != 3) begin bad++; $display("FAIL small_len got=%0d exp=3", q2.size()); end
        else begin
            total++; if (q2[0] !== 8'hA5 || q2[1] !== 8'h00 || q2[2] !== 8'h00) begin
                bad++; $display("FAIL small_bytes got=%h %h %h exp=a5 00 00", q2[0], q2[1], q2[2]);
            end
        end
        total++; if (busy2_cyc != 4) begin bad++; $display("FAIL small_busy got=%0d exp=4", busy2_cyc); end
    endtask

    initial begin
        regs[0] = 32'h0;
        for (int k = 1; k < 32; k++) regs[k] = 32'h1000_0000 + k;
        test_reset();
        test_full_dump();
        test_stall_random();
        test_snapshot();
        test_back_to_back();
        test_reset_abort();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_dump_streamer.md
REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter NUM_REGS, default 32: number of register-file entries dumped; legal range 1..32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: dump request, sampled only in IDLE.
REQ-006 SHALL have port dbg_sel, output, 5 bits: register index driven to the register file debug read-select port.
REQ-007 SHALL have port dbg_data, input, WIDTH bits: combinational debug read data returned for dbg_sel.
REQ-008 SHALL have port tx_data, output, 8 bits: byte offered to the UART transmitter.
REQ-009 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1 bit: UART transmitter accepts a byte.
REQ-011 SHALL have port busy, output, 1 bit: dump in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking dump completion.

Function
REQ-013 SHALL implement the FSM states IDLE, HEADER, LOAD, SEND and DONE.
REQ-014 SHALL transition IDLE->HEADER on an edge where start=1; start SHALL be ignored in every other state.
REQ-015 SHALL drive tx_valid=1 and tx_data=8'hA5 in HEADER, and SHALL go HEADER->LOAD on acceptance.
REQ-016 SHALL define acceptance as a rising edge with tx_valid=1 and tx_ready=1; no other transfer condition exists.
REQ-017 SHALL hold tx_data stable while tx_valid=1 until acceptance, and SHALL NOT deassert tx_valid before acceptance.
REQ-018 SHALL drive dbg_sel = current index in LOAD, last exactly one cycle in LOAD, and capture dbg_data into a WIDTH-bit shift register at the end of that cycle, then enter SEND.
REQ-019 SHALL send WIDTH/8 bytes of the captured word in SEND, most-significant byte first, one byte per acceptance, with tx_valid=1 for the whole state.
REQ-020 SHALL make bytes sent depend only on the captured snapshot; dbg_data changes after LOAD have no effect.
REQ-021 SHALL keep a byte counter (0..WIDTH/8-1) and a register index (0..NUM_REGS-1), both cleared on entry to HEADER.
REQ-022 SHALL, on acceptance of the last byte, go to DONE if index==NUM_REGS-1, otherwise increment the index and go to LOAD.
REQ-023 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL drive busy=1 in HEADER, LOAD and SEND, and busy=0 in IDLE and DONE.
REQ-025 SHALL drive tx_valid=0 in IDLE, LOAD and DONE.
REQ-026 SHALL hold dbg_sel at the current index outside LOAD, and at 0 in IDLE.
REQ-027 SHALL stall indefinitely with no byte loss or duplication while tx_ready=0.
REQ-028 SHALL emit exactly 1 + NUM_REGS*(WIDTH/8) bytes per dump (129 at defaults).
REQ-029 SHALL, with tx_ready held at 1, hold busy high for exactly 1 + NUM_REGS*(1+WIDTH/8) cycles (161 at defaults).

Reset
REQ-030 SHALL, whenever reset=1 and without waiting for clk, force: state IDLE, tx_valid=0, tx_data=0, dbg_sel=0, busy=0, done=0, counters=0 and shift register=0.
REQ-031 SHALL abort a dump in progress on reset, SHALL NOT resume it after reset, and SHALL NOT emit any bytes of it after reset.
REQ-032 SHALL accept the first start on the first rising edge after reset deassertion.

Verification
REQ-033 SHALL be verified with this scenario: preload reg k = 32'h1000_0000+k (x0=0), tx_ready=1, one start pulse -> byte stream A5, 00 00 00 00, 10 00 00 01, ..., 10 00 00 1F (129 bytes); busy high for 161 cycles; done high for 1 cycle.
REQ-034 SHALL be verified with this scenario: tx_ready toggling pseudo-randomly (about 30% high) -> byte sequence identical to the tx_ready=1 case; tx_data constant during every stall.
REQ-035 SHALL be verified with this scenario: change reg 5 from 32'hDEAD_BEEF to 32'h0 while byte 2 of reg 5 is stalled -> remaining bytes of reg 5 still AD BE EF.
REQ-036 SHALL be verified with this scenario: second start pulse during busy -> ignored; exactly 129 bytes and one done pulse.
REQ-037 SHALL be verified with this scenario: reset asserted mid-edge while in SEND for reg 12 -> tx_valid, busy and dbg_sel go to 0 immediately; no further bytes until a new start, which begins with A5 and reg 0.
REQ-038 SHALL be verified with this scenario: NUM_REGS=1, WIDTH=16, reg0=0 -> bytes A5 00 00; busy high for 4 cycles.
